mux_rr_n: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer, the successor to the team's 4:1 combinational mux.
- Selects one input channel per cycle, either by an explicit select (fixed mode) or by round-robin arbitration.
- Delivers the chosen beat through a one-entry output register with valid/ready handshake.
- Sits between multiple producers and a single downstream consumer.

---
 rtl/mux_rr_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/mux_rr_n.sv | 92 +++++++++
 tb/tb_mux_rr_n.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mux_rr_pkg.sv
// Shared constants and helpers for the registered N-channel round-robin mux.
package mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2 for tools without $clog2 in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        int unsigned reach;
        width = 0;
        reach = 1;
        while (reach < value) begin
            reach = reach << 1;
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority search: first requester after ptr wins, ptr itself last.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    logic [SELW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = int'(N); i >= 1; i--) begin
            cand = SELW'((int'(ptr) + i) % int'(N));
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel, W-bit multiplexer with fixed-select or round-robin grant and a
// one-entry registered output stage using a valid/ready handshake.
module mux_rr_n
    import mux_rr_pkg::*;
#(
    parameter  int unsigned N    = 4,
    parameter  int unsigned W    = 8,
    localparam int unsigned SELW = clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_ch,
    input  logic            out_ready
);

    localparam logic [SELW:0] N_EXT = (SELW+1)'(N);

    logic [SELW-1:0] ptr;
    logic            rr_valid;
    logic [SELW-1:0] rr_idx;
    logic            sel_ok;
    logic            grant_valid;
    logic [SELW-1:0] grant_idx;
    logic            can_load;
    logic            xfer;
    logic [W-1:0]    ch_data [N];

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Out-of-range select (non power-of-two N) must never grant.
    assign sel_ok = ({1'b0, sel} < N_EXT);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        unique case (mode)
            MODE_FIXED: begin
                grant_valid = sel_ok && in_valid[sel];
                grant_idx   = sel;
            end
            MODE_RR: begin
                grant_valid = rr_valid;
                grant_idx   = rr_idx;
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int k = 0; k < int'(N); k++) begin
            ch_data[k] = in_data[k*W +: W];
        end
    end

    // Loading while the held beat drains keeps one beat per cycle.
    assign can_load = !out_valid || out_ready;
    assign in_ready = (can_load && grant_valid) ? (N'(1) << grant_idx) : '0;
    assign xfer     = |(in_valid & in_ready);

    // Output register and round-robin pointer; ptr follows the last served channel in both modes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SELW'(N - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[grant_idx];
            out_ch    <= grant_idx;
            ptr       <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed bench for mux_rr_n with a scoreboard queue of expected output beats.
module tb_mux_rr_n;

    logic       clk;
    logic       rst;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] in_valid;
    logic [31:0] in_data;
    logic [3:0] in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_ch;
    logic       out_ready;

    logic [7:0] dat [4];
    logic [9:0] sb [$];
    int tests;
    int fails;

    mux_rr_n #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign in_data = {dat[3], dat[2], dat[1], dat[0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every beat the consumer accepts must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", {22'd0, out_data, out_ch}, 32'h3ff);
            end else begin
                logic [9:0] e;
                e = sb.pop_front();
                chk("out_beat", {22'd0, out_data, out_ch}, {22'd0, e});
            end
        end
    end

    // One cycle: drive after the edge, check in_ready mid-cycle, record the expected beat.
    task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v,
                        input logic r, input logic [3:0] exp_rdy, input int exp_ch);
        logic [1:0] c;
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = r;
        @(negedge clk);
        chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
        if (exp_ch >= 0) begin
            c = 2'(exp_ch);
            sb.push_back({dat[c], c});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int k = 0; k < 4; k++) dat[k] = 8'h10 + 8'(k);
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_ch", {30'd0, out_ch}, 32'd0);
        rst = 1'b0;

        // 1: fixed select walks all channels
        step(1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 0);
        step(1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1);
        step(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 2);
        step(1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 3);
        step(1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, -1);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // 2: round-robin, all requesting, after reset starts at channel 0
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001 << (i % 4), i % 4);
            chk("rr_valid_cont", {31'd0, out_valid}, 32'd1);
        end

        // 3: sparse requests alternate, then a single requester repeats
        step(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1);
        step(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 3);
        step(1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1);
        step(1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 3);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1);

        // 4: backpressure holds the beat; release loads the next without a bubble
        dat[2] = 8'hA5;
        step(1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 2);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, -1);
            chk("bp_data", {24'd0, out_data}, 32'hA5);
            chk("bp_ch", {30'd0, out_ch}, 32'd2);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
        end
        step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 3);
        chk("no_bubble", {31'd0, out_valid}, 32'd1);
        step(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, -1);

        // 5: fixed select on an idle channel never grants
        step(1'b0, 2'd0, 4'b1101, 1'b1, 4'b0001, 0);
        step(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, -1);
        chk("fixed_idle_drop", {31'd0, out_valid}, 32'd0);
        step(1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1);
        chk("fixed_grant", {31'd0, out_valid}, 32'd1);

        // 6: async reset mid-stream discards the beat; rr restarts at channel 0
        step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 2);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_data", {24'd0, out_data}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 0);
        step(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, -1);
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
